// File: rtl/vctr_fetch_pkg.sv
// Shared types and constants for the vector fetch engine.
// Optional latency monitor is enabled with VCTR_FETCH_LAT_MON_EN (see vctr_fetch.sv).
package vctr_fetch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        ISSUE,
        WAIT,
        PUSH
    } state_t;

    localparam int WORD_BYTES = 4;
    localparam int CNT_W      = 16;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO with registered count/full.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo_fwft
    import vctr_fetch_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             wr,
    input  logic             rd,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;
    logic [CNT_W-1:0] count_next;

    assign empty   = (count == '0);
    assign do_pop  = rd && !empty;
    assign do_push = wr && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_next = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next;
            full  <= (count_next == CNT_W'(DEPTH));
        end
    end

    // Storage needs no reset; the head is only consumed when count is non-zero.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/vctr_fetch.sv
// Fetches WORDS_PER_VECTOR words per queued base address into the vector FIFO.
// Define VCTR_FETCH_LAT_MON_EN to track the worst-case read latency on max_rd_latency.
module vctr_fetch
    import vctr_fetch_pkg::*;
#(
    parameter int ADDR_FIFO_DEPTH  = 16,
    parameter int WORDS_PER_VECTOR = 4,
    parameter int RD_TIMEOUT       = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      addr_fifo_din,
    input  logic             addr_fifo_wr,
    output logic             addr_fifo_full,
    output logic             addr_fifo_rd,
    output logic [CNT_W-1:0] addr_fifo_count,
    output logic [31:0]      master_addr,
    output logic             master_rd,
    input  logic             master_waitrequest,
    input  logic [31:0]      master_data_in,
    input  logic             master_data_in_val,
    output logic [31:0]      vctr_fifo_din,
    output logic             vctr_fifo_wr,
    input  logic             vctr_fifo_full,
    input  logic             err_clr,
    output logic             fetch_busy,
    output logic [CNT_W-1:0] vectors_fetched,
    output logic             rd_timeout_err,
    output logic [CNT_W-1:0] max_rd_latency
);

    localparam int               IDX_W     = 9;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WORDS_PER_VECTOR - 1);
    localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(RD_TIMEOUT);

    state_t           state;
    state_t           state_next;
    logic [31:0]      fifo_head;
    logic             fifo_empty;
    logic [31:0]      base_addr;
    logic [IDX_W-1:0] word_idx;
    logic [31:0]      rd_data;
    logic [CNT_W-1:0] tmo_cnt;
    logic [CNT_W-1:0] tmo_next;
    logic             tmo_hit;
    logic             word_done;
    logic             last_word;

    sync_fifo_fwft #(
        .DEPTH (ADDR_FIFO_DEPTH),
        .WIDTH (32)
    ) u_addr_fifo (
        .clk   (clk),
        .reset (reset),
        .din   (addr_fifo_din),
        .wr    (addr_fifo_wr),
        .rd    (addr_fifo_rd),
        .dout  (fifo_head),
        .count (addr_fifo_count),
        .full  (addr_fifo_full),
        .empty (fifo_empty)
    );

    assign tmo_next  = tmo_cnt + CNT_W'(1);
    assign tmo_hit   = (state == WAIT) && !master_data_in_val && (tmo_next == TMO_LIMIT);
    assign word_done = (state == PUSH) && !vctr_fifo_full;
    assign last_word = (word_idx == LAST_IDX);

    // Outputs decode straight from the state so a reset drops master_rd without waiting for a clock.
    assign addr_fifo_rd  = (state == POP);
    assign master_rd     = (state == ISSUE);
    assign master_addr   = master_rd ? (base_addr + (32'(word_idx) * 32'(WORD_BYTES))) : 32'd0;
    assign vctr_fifo_wr  = word_done;
    assign vctr_fifo_din = rd_data;
    assign fetch_busy    = (state != IDLE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    state_next = POP;
                end
            end
            POP: begin
                state_next = ISSUE;
            end
            ISSUE: begin
                if (!master_waitrequest) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (master_data_in_val) begin
                    state_next = PUSH;
                end else if (tmo_hit) begin
                    state_next = IDLE;
                end
            end
            PUSH: begin
                if (word_done) begin
                    state_next = last_word ? IDLE : ISSUE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            base_addr       <= '0;
            word_idx        <= '0;
            rd_data         <= '0;
            tmo_cnt         <= '0;
            vectors_fetched <= '0;
        end else begin
            state <= state_next;
            case (state)
                POP: begin
                    base_addr <= fifo_head;
                    word_idx  <= '0;
                end
                ISSUE: begin
                    if (!master_waitrequest) begin
                        tmo_cnt <= '0;
                    end
                end
                WAIT: begin
                    if (master_data_in_val) begin
                        rd_data <= master_data_in;
                    end else begin
                        tmo_cnt <= tmo_next;
                    end
                end
                PUSH: begin
                    if (!vctr_fifo_full) begin
                        word_idx <= word_idx + IDX_W'(1);
                        if (last_word) begin
                            vectors_fetched <= vectors_fetched + CNT_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // A timeout in the same cycle as err_clr must leave the flag set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_timeout_err <= 1'b0;
        end else if (tmo_hit) begin
            rd_timeout_err <= 1'b1;
        end else if (err_clr) begin
            rd_timeout_err <= 1'b0;
        end
    end

`ifdef VCTR_FETCH_LAT_MON_EN
    // The timeout counter already holds the WAIT cycles elapsed, so latency is that plus the beat cycle.
    logic [CNT_W:0] lat_sample;

    assign lat_sample = {1'b0, tmo_cnt} + (CNT_W + 1)'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            max_rd_latency <= '0;
        end else if (err_clr) begin
            max_rd_latency <= '0;
        end else if ((state == WAIT) && master_data_in_val && (lat_sample > {1'b0, max_rd_latency})) begin
            max_rd_latency <= lat_sample[CNT_W] ? '1 : lat_sample[CNT_W-1:0];
        end
    end
`else
    assign max_rd_latency = '0;
`endif

endmodule

// File: tb/tb_vctr_fetch.sv
// Directed testbench for vctr_fetch with a scripted single-outstanding slave model.
// Expected max_rd_latency values follow VCTR_FETCH_LAT_MON_EN.
module tb_vctr_fetch;

`ifdef VCTR_FETCH_LAT_MON_EN
    localparam bit LAT_EN = 1'b1;
`else
    localparam bit LAT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] addr_fifo_din = '0;
    logic        addr_fifo_wr = 1'b0;
    logic        addr_fifo_full;
    logic        addr_fifo_rd;
    logic [15:0] addr_fifo_count;
    logic [31:0] master_addr;
    logic        master_rd;
    logic        master_waitrequest = 1'b0;
    logic [31:0] master_data_in = '0;
    logic        master_data_in_val = 1'b0;
    logic [31:0] vctr_fifo_din;
    logic        vctr_fifo_wr;
    logic        vctr_fifo_full = 1'b0;
    logic        err_clr = 1'b0;
    logic        fetch_busy;
    logic [15:0] vectors_fetched;
    logic        rd_timeout_err;
    logic [15:0] max_rd_latency;

    int checks = 0;
    int errors = 0;

    vctr_fetch #(
        .ADDR_FIFO_DEPTH  (16),
        .WORDS_PER_VECTOR (4),
        .RD_TIMEOUT       (10)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .addr_fifo_din      (addr_fifo_din),
        .addr_fifo_wr       (addr_fifo_wr),
        .addr_fifo_full     (addr_fifo_full),
        .addr_fifo_rd       (addr_fifo_rd),
        .addr_fifo_count    (addr_fifo_count),
        .master_addr        (master_addr),
        .master_rd          (master_rd),
        .master_waitrequest (master_waitrequest),
        .master_data_in     (master_data_in),
        .master_data_in_val (master_data_in_val),
        .vctr_fifo_din      (vctr_fifo_din),
        .vctr_fifo_wr       (vctr_fifo_wr),
        .vctr_fifo_full     (vctr_fifo_full),
        .err_clr            (err_clr),
        .fetch_busy         (fetch_busy),
        .vectors_fetched    (vectors_fetched),
        .rd_timeout_err     (rd_timeout_err),
        .max_rd_latency     (max_rd_latency)
    );

    always #5 clk = ~clk;

    // Bus monitor: samples mid-cycle and logs accepted reads, vector writes and pops.
    int          cyc = 0;
    logic [31:0] aq[$];
    int          acc_cyc[$];
    logic [31:0] wq[$];
    int          pop_cnt = 0;
    int          stall_cnt = 0;
    int          unstable_cnt = 0;
    int          wr_full_cnt = 0;
    logic        acc_seen = 1'b0;
    logic [31:0] acc_addr = '0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr = '0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        acc_seen = master_rd && !master_waitrequest;
        acc_addr = master_addr;
        if (acc_seen) begin
            aq.push_back(master_addr);
            acc_cyc.push_back(cyc);
        end
        if (vctr_fifo_wr) begin
            wq.push_back(vctr_fifo_din);
            if (vctr_fifo_full) wr_full_cnt++;
        end
        if (addr_fifo_rd) pop_cnt++;
        if (master_rd && master_waitrequest) stall_cnt++;
        if (prev_stall && (!master_rd || master_addr != prev_addr)) unstable_cnt++;
        prev_stall = master_rd && master_waitrequest;
        prev_addr  = master_addr;
    end

    // Slave model: returns data equal to the accepted address after ctl_lat cycles.
    int   ctl_stall = 0;
    int   ctl_mute = 0;
    int   ctl_inject = 0;
    int   ctl_lat = 1;
    int   ctl_gen = 0;
    logic ctl_hold = 1'b0;
    int          s_gen = 0;
    int          s_stall = 0;
    int          s_mute = 0;
    int          s_inject = 0;
    int          s_lat_left = 0;
    logic        s_busy = 1'b0;
    logic [31:0] s_data = '0;

    always @(posedge clk) begin
        #1;
        if (ctl_gen != s_gen) begin
            s_gen    = ctl_gen;
            s_stall  = ctl_stall;
            s_mute   = ctl_mute;
            s_inject = ctl_inject;
        end
        master_data_in_val = 1'b0;
        if (!reset) begin
            s_busy = 1'b0;
        end else begin
            if (acc_seen) begin
                if (s_mute > 0) begin
                    s_mute--;
                end else begin
                    s_busy     = 1'b1;
                    s_lat_left = ctl_lat;
                    s_data     = acc_addr;
                end
            end
            if (s_busy) begin
                if (s_lat_left <= 1) begin
                    master_data_in_val = 1'b1;
                    master_data_in     = s_data;
                    s_busy             = 1'b0;
                end else begin
                    s_lat_left--;
                end
            end
            if (s_inject > 0) begin
                master_data_in_val = 1'b1;
                master_data_in     = 32'hDEAD_BEEF;
                s_inject--;
            end
        end
        if (ctl_hold) begin
            master_waitrequest = 1'b1;
        end else if (master_rd && s_stall > 0) begin
            master_waitrequest = 1'b1;
            s_stall--;
        end else begin
            master_waitrequest = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a);
        addr_fifo_din = a;
        addr_fifo_wr  = 1'b1;
        step();
        addr_fifo_wr  = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            step();
            if (!fetch_busy && addr_fifo_count == 16'd0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_accept(input int base, input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            step();
            if (aq.size() > base) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step();
        step();
        checks++; if (master_rd !== 1'b0) begin errors++; $display("[TB] FAIL reset_master_rd: got %b expected 0", master_rd); end
        checks++; if (master_addr !== 32'd0) begin errors++; $display("[TB] FAIL reset_master_addr: got %h expected 0", master_addr); end
        checks++; if (addr_fifo_count !== 16'd0 || addr_fifo_full !== 1'b0) begin errors++; $display("[TB] FAIL reset_fifo: got count %0d full %b expected 0/0", addr_fifo_count, addr_fifo_full); end
        checks++; if (fetch_busy !== 1'b0 || vctr_fifo_wr !== 1'b0 || addr_fifo_rd !== 1'b0) begin errors++; $display("[TB] FAIL reset_strobes: got busy %b wr %b rd %b expected 0", fetch_busy, vctr_fifo_wr, addr_fifo_rd); end
        checks++; if (vectors_fetched !== 16'd0 || rd_timeout_err !== 1'b0 || max_rd_latency !== 16'd0) begin errors++; $display("[TB] FAIL reset_status: got vec %0d err %b lat %0d expected 0", vectors_fetched, rd_timeout_err, max_rd_latency); end
        reset = 1'b1;
        step();
        step();
        checks++; if (fetch_busy !== 1'b0 || addr_fifo_count !== 16'd0) begin errors++; $display("[TB] FAIL post_reset_idle: got busy %b count %0d expected 0", fetch_busy, addr_fifo_count); end
    endtask

    task automatic test_basic();
        int b = aq.size();
        int wb = wq.size();
        int p0 = pop_cnt;
        bit ok;
        push(32'h0000_1000);
        checks++; if (addr_fifo_count !== 16'd1 || master_rd !== 1'b0) begin errors++; $display("[TB] FAIL basic_count_update: got count %0d rd %b expected 1/0", addr_fifo_count, master_rd); end
        step();
        checks++; if (addr_fifo_rd !== 1'b1) begin errors++; $display("[TB] FAIL basic_pop_strobe: got %b expected 1", addr_fifo_rd); end
        step();
        checks++; if (master_rd !== 1'b1 || master_addr !== 32'h0000_1000) begin errors++; $display("[TB] FAIL basic_first_issue: got rd %b addr %h expected 1/00001000", master_rd, master_addr); end
        wait_idle(200, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL basic_idle_timeout: got busy %b expected idle within 200 cycles", fetch_busy); end
        checks++; if (aq.size() !== b + 4 || wq.size() !== wb + 4) begin errors++; $display("[TB] FAIL basic_counts: got %0d reads %0d writes expected 4/4", aq.size() - b, wq.size() - wb); end
        for (int i = 0; i < 4; i++) begin
            logic [31:0] exp_a = 32'h0000_1000 + 32'(i * 4);
            if (b + i < aq.size() && wb + i < wq.size()) begin
                checks++; if (aq[b+i] !== exp_a || wq[wb+i] !== exp_a) begin errors++; $display("[TB] FAIL basic_word%0d: got addr %h data %h expected %h", i, aq[b+i], wq[wb+i], exp_a); end
            end
        end
        for (int i = 1; i < 4; i++) begin
            if (b + i < acc_cyc.size()) begin
                checks++; if (acc_cyc[b+i] - acc_cyc[b+i-1] != 3) begin errors++; $display("[TB] FAIL basic_word_period%0d: got %0d expected 3", i, acc_cyc[b+i] - acc_cyc[b+i-1]); end
            end
        end
        checks++; if (pop_cnt - p0 != 1) begin errors++; $display("[TB] FAIL basic_pops: got %0d expected 1", pop_cnt - p0); end
        checks++; if (vectors_fetched !== 16'd1) begin errors++; $display("[TB] FAIL basic_vectors: got %0d expected 1", vectors_fetched); end
        checks++; if (max_rd_latency !== (LAT_EN ? 16'd1 : 16'd0)) begin errors++; $display("[TB] FAIL basic_max_latency: got %0d expected %0d", max_rd_latency, LAT_EN ? 1 : 0); end
    endtask

    task automatic test_waitrequest();
        int b = aq.size();
        int wb = wq.size();
        int s0 = stall_cnt;
        int u0 = unstable_cnt;
        bit ok;
        ctl_stall = 5;
        ctl_lat   = 3;
        ctl_gen++;
        push(32'h0000_2000);
        wait_idle(300, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL waitreq_idle_timeout: got busy %b expected idle within 300 cycles", fetch_busy); end
        checks++; if (stall_cnt - s0 != 5) begin errors++; $display("[TB] FAIL waitreq_stall_cycles: got %0d expected 5", stall_cnt - s0); end
        checks++; if (unstable_cnt != u0) begin errors++; $display("[TB] FAIL waitreq_hold_stable: got %0d changes expected 0", unstable_cnt - u0); end
        checks++; if (aq.size() !== b + 4 || wq.size() !== wb + 4) begin errors++; $display("[TB] FAIL waitreq_counts: got %0d reads %0d writes expected 4/4", aq.size() - b, wq.size() - wb); end
        for (int i = 0; i < 4; i++) begin
            logic [31:0] exp_a = 32'h0000_2000 + 32'(i * 4);
            if (b + i < aq.size() && wb + i < wq.size()) begin
                checks++; if (aq[b+i] !== exp_a || wq[wb+i] !== exp_a) begin errors++; $display("[TB] FAIL waitreq_word%0d: got addr %h data %h expected %h", i, aq[b+i], wq[wb+i], exp_a); end
            end
        end
        checks++; if (vectors_fetched !== 16'd2) begin errors++; $display("[TB] FAIL waitreq_vectors: got %0d expected 2", vectors_fetched); end
        checks++; if (max_rd_latency !== (LAT_EN ? 16'd3 : 16'd0)) begin errors++; $display("[TB] FAIL waitreq_max_latency: got %0d expected %0d", max_rd_latency, LAT_EN ? 3 : 0); end
        ctl_stall = 0;
        ctl_lat   = 1;
        ctl_gen++;
    endtask

    task automatic test_timeout();
        int b = aq.size();
        int wb = wq.size();
        bit ok;
        ctl_mute = 1;
        ctl_gen++;
        push(32'h0000_3000);
        push(32'h0000_4000);
        wait_accept(b, 50, ok);
        checks++; if (!ok || aq[b] !== 32'h0000_3000) begin errors++; $display("[TB] FAIL timeout_first_read: got ok %b expected read of 00003000", ok); end
        repeat (9) step();
        checks++; if (rd_timeout_err !== 1'b0 || fetch_busy !== 1'b1) begin errors++; $display("[TB] FAIL timeout_early: got err %b busy %b after 9 WAIT cycles expected 0/1", rd_timeout_err, fetch_busy); end
        step();
        checks++; if (rd_timeout_err !== 1'b1 || fetch_busy !== 1'b0) begin errors++; $display("[TB] FAIL timeout_at_limit: got err %b busy %b after 10 WAIT cycles expected 1/0", rd_timeout_err, fetch_busy); end
        checks++; if (vectors_fetched !== 16'd2) begin errors++; $display("[TB] FAIL timeout_vectors_unchanged: got %0d expected 2", vectors_fetched); end
        wait_idle(200, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL timeout_idle_timeout: got busy %b expected idle within 200 cycles", fetch_busy); end
        checks++; if (aq.size() !== b + 5 || wq.size() !== wb + 4) begin errors++; $display("[TB] FAIL timeout_counts: got %0d reads %0d writes expected 5/4", aq.size() - b, wq.size() - wb); end
        for (int i = 0; i < 4; i++) begin
            logic [31:0] exp_a = 32'h0000_4000 + 32'(i * 4);
            if (b + 1 + i < aq.size() && wb + i < wq.size()) begin
                checks++; if (aq[b+1+i] !== exp_a || wq[wb+i] !== exp_a) begin errors++; $display("[TB] FAIL timeout_next_word%0d: got addr %h data %h expected %h", i, aq[b+1+i], wq[wb+i], exp_a); end
            end
        end
        checks++; if (vectors_fetched !== 16'd3 || rd_timeout_err !== 1'b1) begin errors++; $display("[TB] FAIL timeout_after_next: got vec %0d err %b expected 3/1", vectors_fetched, rd_timeout_err); end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        checks++; if (rd_timeout_err !== 1'b0 || max_rd_latency !== 16'd0) begin errors++; $display("[TB] FAIL timeout_err_clr: got err %b lat %0d expected 0/0", rd_timeout_err, max_rd_latency); end
    endtask

    task automatic test_vctr_full();
        int b = aq.size();
        int wb = wq.size();
        int f0 = wr_full_cnt;
        int w0;
        bit ok;
        vctr_fifo_full = 1'b1;
        push(32'h0000_5000);
        wait_accept(b, 50, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL vfull_accept_timeout: got no read expected read of 00005000"); end
        w0 = wq.size();
        repeat (9) step();
        checks++; if (wq.size() !== w0 || fetch_busy !== 1'b1) begin errors++; $display("[TB] FAIL vfull_no_write: got %0d writes busy %b expected 0/1", wq.size() - w0, fetch_busy); end
        vctr_fifo_full = 1'b0;
        wait_idle(200, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL vfull_idle_timeout: got busy %b expected idle within 200 cycles", fetch_busy); end
        checks++; if (wq.size() !== wb + 4 || wr_full_cnt != f0) begin errors++; $display("[TB] FAIL vfull_counts: got %0d writes %0d while full expected 4/0", wq.size() - wb, wr_full_cnt - f0); end
        for (int i = 0; i < 4; i++) begin
            logic [31:0] exp_a = 32'h0000_5000 + 32'(i * 4);
            if (wb + i < wq.size()) begin
                checks++; if (wq[wb+i] !== exp_a) begin errors++; $display("[TB] FAIL vfull_word%0d: got %h expected %h", i, wq[wb+i], exp_a); end
            end
        end
        checks++; if (vectors_fetched !== 16'd4) begin errors++; $display("[TB] FAIL vfull_vectors: got %0d expected 4", vectors_fetched); end
    endtask

    task automatic test_back_to_back();
        int b = aq.size();
        int p0 = pop_cnt;
        int bad = 0;
        bit ok;
        ctl_hold = 1'b1;
        push(32'h0000_6000);
        repeat (4) step();
        checks++; if (master_rd !== 1'b1 || addr_fifo_count !== 16'd0) begin errors++; $display("[TB] FAIL b2b_stalled_issue: got rd %b count %0d expected 1/0", master_rd, addr_fifo_count); end
        for (int i = 0; i < 17; i++) begin
            addr_fifo_din = 32'h0001_0000 + 32'(i * 256);
            addr_fifo_wr  = 1'b1;
            step();
            if (i == 14) begin
                checks++; if (addr_fifo_count !== 16'd15 || addr_fifo_full !== 1'b0) begin errors++; $display("[TB] FAIL b2b_15_pushes: got count %0d full %b expected 15/0", addr_fifo_count, addr_fifo_full); end
            end
            if (i == 15) begin
                checks++; if (addr_fifo_count !== 16'd16 || addr_fifo_full !== 1'b1) begin errors++; $display("[TB] FAIL b2b_16_pushes: got count %0d full %b expected 16/1", addr_fifo_count, addr_fifo_full); end
            end
        end
        addr_fifo_wr = 1'b0;
        checks++; if (addr_fifo_count !== 16'd16 || addr_fifo_full !== 1'b1) begin errors++; $display("[TB] FAIL b2b_17th_dropped: got count %0d full %b expected 16/1", addr_fifo_count, addr_fifo_full); end
        ctl_hold = 1'b0;
        wait_idle(2000, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL b2b_idle_timeout: got busy %b count %0d expected idle within 2000 cycles", fetch_busy, addr_fifo_count); end
        checks++; if (aq.size() !== b + 68 || pop_cnt - p0 != 17) begin errors++; $display("[TB] FAIL b2b_counts: got %0d reads %0d pops expected 68/17", aq.size() - b, pop_cnt - p0); end
        for (int k = 0; k < 16; k++) begin
            if (b + 4 * (k + 1) >= aq.size() || aq[b + 4*(k+1)] !== 32'h0001_0000 + 32'(k * 256)) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("[TB] FAIL b2b_order: got %0d wrong vector bases expected 0", bad); end
        checks++; if (vectors_fetched !== 16'd21) begin errors++; $display("[TB] FAIL b2b_vectors: got %0d expected 21", vectors_fetched); end
    endtask

    task automatic test_reset_midread();
        int wb = wq.size();
        int busy_seen = 0;
        ctl_hold = 1'b1;
        push(32'h0000_7000);
        push(32'h0000_7100);
        repeat (5) step();
        checks++; if (master_rd !== 1'b1 || addr_fifo_count !== 16'd1) begin errors++; $display("[TB] FAIL rst_mid_setup: got rd %b count %0d expected 1/1", master_rd, addr_fifo_count); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (master_rd !== 1'b0 || master_addr !== 32'd0) begin errors++; $display("[TB] FAIL rst_mid_rd_drop: got rd %b addr %h expected 0/0", master_rd, master_addr); end
        checks++; if (addr_fifo_count !== 16'd0 || fetch_busy !== 1'b0 || vectors_fetched !== 16'd0) begin errors++; $display("[TB] FAIL rst_mid_state: got count %0d busy %b vec %0d expected 0", addr_fifo_count, fetch_busy, vectors_fetched); end
        step();
        ctl_hold   = 1'b0;
        ctl_inject = 3;
        ctl_gen++;
        reset      = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (fetch_busy) busy_seen++;
        end
        checks++; if (busy_seen != 0) begin errors++; $display("[TB] FAIL rst_late_val_busy: got %0d busy cycles expected 0", busy_seen); end
        checks++; if (wq.size() !== wb || vectors_fetched !== 16'd0 || addr_fifo_count !== 16'd0) begin errors++; $display("[TB] FAIL rst_late_val_ignored: got %0d writes vec %0d count %0d expected 0", wq.size() - wb, vectors_fetched, addr_fifo_count); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_waitrequest();
        test_timeout();
        test_vctr_full();
        test_back_to_back();
        test_reset_midread();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion expected finish before 200000ns");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
